// File: rtl/uart_bus_arbiter_pkg.sv
// Shared widths, access-size encodings and types for the UART bus arbiter slice.
package uart_bus_arbiter_pkg;

  localparam int unsigned UART_VA_WIDTH = 3;
  localparam int unsigned BUS_WIDTH     = 32;
  localparam int unsigned BUS_ACC_WIDTH = 2;

  localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_1B = 2'd0;
  localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_2B = 2'd1;
  localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_4B = 2'd2;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [UART_VA_WIDTH-1:0] addr;
    logic                     w_rb;
    logic [BUS_ACC_WIDTH-1:0] acc;
    logic [BUS_WIDTH-1:0]     wdata;
  } bus_cmd_t;

endpackage

// File: rtl/uart_arb_slot.sv
// Per-master pending slot: captures a request's fields and presents either the
// held command (when valid) or the live bus fields.
module uart_arb_slot
  import uart_bus_arbiter_pkg::*;
(
  input  logic     clk,
  input  logic     rstn,
  input  bus_cmd_t live,
  input  logic     capture,
  input  logic     clear,
  output logic     valid,
  output bus_cmd_t cmd
);

  bus_cmd_t held;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid <= 1'b0;
      held  <= '0;
    end else if (capture) begin
      valid <= 1'b1;
      held  <= live;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

  assign cmd = valid ? held : live;

endmodule

// File: rtl/uart_bus_arbiter.sv
// Two-master arbiter in front of uart_controller: transparent when uncontended,
// contended requests parked in a pending slot and issued after the current one.
module uart_bus_arbiter
  import uart_bus_arbiter_pkg::*;
#(
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [UART_VA_WIDTH-1:0] m0_addr,
  input  logic                     m0_w_rb,
  input  logic [BUS_ACC_WIDTH-1:0] m0_acc,
  input  logic [BUS_WIDTH-1:0]     m0_wdata,
  input  logic                     m0_req,
  output logic [BUS_WIDTH-1:0]     m0_rdata,
  output logic                     m0_resp,
  output logic                     m0_fault,
  input  logic [UART_VA_WIDTH-1:0] m1_addr,
  input  logic                     m1_w_rb,
  input  logic [BUS_ACC_WIDTH-1:0] m1_acc,
  input  logic [BUS_WIDTH-1:0]     m1_wdata,
  input  logic                     m1_req,
  output logic [BUS_WIDTH-1:0]     m1_rdata,
  output logic                     m1_resp,
  output logic                     m1_fault,
  output logic [UART_VA_WIDTH-1:0] s_addr,
  output logic                     s_w_rb,
  output logic [BUS_ACC_WIDTH-1:0] s_acc,
  output logic [BUS_WIDTH-1:0]     s_wdata,
  output logic                     s_req,
  input  logic [BUS_WIDTH-1:0]     s_rdata,
  input  logic                     s_resp,
  input  logic                     s_fault
);

  arb_state_t state, state_nxt;
  logic       owner, owner_nxt;
  logic       last, last_nxt;

  bus_cmd_t live0, live1, cmd0, cmd1, issue_cmd;
  logic     pv0, pv1, cap0, cap1, clr0, clr1;
  logic     cand0, cand1, grant, winner;

  assign live0 = '{addr: m0_addr, w_rb: m0_w_rb, acc: m0_acc, wdata: m0_wdata};
  assign live1 = '{addr: m1_addr, w_rb: m1_w_rb, acc: m1_acc, wdata: m1_wdata};

  uart_arb_slot u_slot0 (
    .clk     (clk),
    .rstn    (rstn),
    .live    (live0),
    .capture (cap0),
    .clear   (clr0),
    .valid   (pv0),
    .cmd     (cmd0)
  );

  uart_arb_slot u_slot1 (
    .clk     (clk),
    .rstn    (rstn),
    .live    (live1),
    .capture (cap1),
    .clear   (clr1),
    .valid   (pv1),
    .cmd     (cmd1)
  );

  // Issue path kept apart from the control block so s_fault (a function of
  // s_req downstream) never loops back into s_req.
  always_comb begin
    cand0     = pv0 | m0_req;
    cand1     = pv1 | m1_req;
    grant     = 1'b0;
    winner    = cand1;
    if (cand0 && cand1) begin
      winner = PRIO_FIXED ? 1'b0 : ~last;
    end
    issue_cmd = winner ? cmd1 : cmd0;
    s_addr    = issue_cmd.addr;
    s_w_rb    = issue_cmd.w_rb;
    s_acc     = issue_cmd.acc;
    s_wdata   = issue_cmd.wdata;
    if (rstn && state == IDLE) begin
      grant = cand0 | cand1;
    end
    s_req = grant;
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last;
    cap0      = 1'b0;
    cap1      = 1'b0;
    clr0      = 1'b0;
    clr1      = 1'b0;
    m0_resp   = 1'b0;
    m1_resp   = 1'b0;
    m0_fault  = 1'b0;
    m1_fault  = 1'b0;
    if (rstn) begin
      unique case (state)
        IDLE: begin
          if (grant) begin
            last_nxt = winner;
            clr0     = ~winner;
            clr1     = winner;
            cap0     = winner & m0_req & ~pv0;
            cap1     = ~winner & m1_req & ~pv1;
            if (s_fault) begin
              m0_fault = ~winner;
              m1_fault = winner;
            end else begin
              owner_nxt = winner;
              state_nxt = WAIT;
            end
          end
        end
        WAIT: begin
          cap0 = m0_req & ~pv0 & owner;
          cap1 = m1_req & ~pv1 & ~owner;
          if (s_resp) begin
            m0_resp   = ~owner;
            m1_resp   = owner;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      last  <= last_nxt;
    end
  end

  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Scoreboard bench for uart_bus_arbiter: per-cycle stimulus and expected bus
// observations are queued together, then replayed against RR and fixed instances.
module tb_uart_bus_arbiter;
  import uart_bus_arbiter_pkg::*;

  localparam logic [31:0] RD_BASE = 32'hC0DE_0000;

  typedef struct packed {
    logic        rst;
    logic        inj;
    logic        q0;
    logic [2:0]  a0;
    logic        w0;
    logic [1:0]  c0;
    logic [31:0] d0;
    logic        q1;
    logic [2:0]  a1;
    logic        w1;
    logic [1:0]  c1;
    logic [31:0] d1;
  } stim_t;

  typedef struct packed {
    logic        req;
    logic [2:0]  addr;
    logic        w_rb;
    logic [1:0]  acc;
    logic [31:0] wdata;
    logic        r0;
    logic        r1;
    logic        f0;
    logic        f1;
    logic [31:0] d0;
    logic [31:0] d1;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn = 1'b0;
  logic        inj = 1'b0;
  logic [2:0]  m0_addr = '0, m1_addr = '0;
  logic        m0_w_rb = 1'b0, m1_w_rb = 1'b0;
  logic [1:0]  m0_acc = '0, m1_acc = '0;
  logic [31:0] m0_wdata = '0, m1_wdata = '0;
  logic        m0_req = 1'b0, m1_req = 1'b0;

  logic [31:0] rr_m0_rdata, rr_m1_rdata, fx_m0_rdata, fx_m1_rdata;
  logic        rr_m0_resp, rr_m1_resp, rr_m0_fault, rr_m1_fault;
  logic        fx_m0_resp, fx_m1_resp, fx_m0_fault, fx_m1_fault;
  logic [2:0]  rr_s_addr, fx_s_addr;
  logic        rr_s_w_rb, fx_s_w_rb, rr_s_req, fx_s_req;
  logic [1:0]  rr_s_acc, fx_s_acc;
  logic [31:0] rr_s_wdata, fx_s_wdata;
  logic [31:0] rr_rdata_q = '0, fx_rdata_q = '0;
  logic        rr_resp_q = 1'b0, fx_resp_q = 1'b0;
  logic        rr_s_resp, fx_s_resp, rr_s_fault, fx_s_fault;

  uart_bus_arbiter #(.PRIO_FIXED(1'b0)) u_rr (
    .clk(clk), .rstn(rstn),
    .m0_addr(m0_addr), .m0_w_rb(m0_w_rb), .m0_acc(m0_acc), .m0_wdata(m0_wdata), .m0_req(m0_req),
    .m0_rdata(rr_m0_rdata), .m0_resp(rr_m0_resp), .m0_fault(rr_m0_fault),
    .m1_addr(m1_addr), .m1_w_rb(m1_w_rb), .m1_acc(m1_acc), .m1_wdata(m1_wdata), .m1_req(m1_req),
    .m1_rdata(rr_m1_rdata), .m1_resp(rr_m1_resp), .m1_fault(rr_m1_fault),
    .s_addr(rr_s_addr), .s_w_rb(rr_s_w_rb), .s_acc(rr_s_acc), .s_wdata(rr_s_wdata), .s_req(rr_s_req),
    .s_rdata(rr_rdata_q), .s_resp(rr_s_resp), .s_fault(rr_s_fault)
  );

  uart_bus_arbiter #(.PRIO_FIXED(1'b1)) u_fx (
    .clk(clk), .rstn(rstn),
    .m0_addr(m0_addr), .m0_w_rb(m0_w_rb), .m0_acc(m0_acc), .m0_wdata(m0_wdata), .m0_req(m0_req),
    .m0_rdata(fx_m0_rdata), .m0_resp(fx_m0_resp), .m0_fault(fx_m0_fault),
    .m1_addr(m1_addr), .m1_w_rb(m1_w_rb), .m1_acc(m1_acc), .m1_wdata(m1_wdata), .m1_req(m1_req),
    .m1_rdata(fx_m1_rdata), .m1_resp(fx_m1_resp), .m1_fault(fx_m1_fault),
    .s_addr(fx_s_addr), .s_w_rb(fx_s_w_rb), .s_acc(fx_s_acc), .s_wdata(fx_s_wdata), .s_req(fx_s_req),
    .s_rdata(fx_rdata_q), .s_resp(fx_s_resp), .s_fault(fx_s_fault)
  );

  // Controller model: faults non-byte accesses and writes to register 2,
  // otherwise responds one cycle after the request. Not reset on purpose.
  function automatic logic bad(input logic [2:0] a, input logic w, input logic [1:0] c);
    return (c != BUS_ACC_1B) || (w && a == 3'd2);
  endfunction

  assign rr_s_fault = rr_s_req && bad(rr_s_addr, rr_s_w_rb, rr_s_acc);
  assign fx_s_fault = fx_s_req && bad(fx_s_addr, fx_s_w_rb, fx_s_acc);
  assign rr_s_resp  = rr_resp_q | inj;
  assign fx_s_resp  = fx_resp_q | inj;

  always @(posedge clk) begin
    rr_resp_q <= rr_s_req && !rr_s_fault;
    fx_resp_q <= fx_s_req && !fx_s_fault;
    if (rr_s_req) rr_rdata_q <= RD_BASE | 32'(rr_s_addr);
    if (fx_s_req) fx_rdata_q <= RD_BASE | 32'(fx_s_addr);
  end

  obs_t obs_rr, obs_fx;
  always_comb begin
    obs_rr = '0;
    obs_rr.req = rr_s_req;
    if (rr_s_req) {obs_rr.addr, obs_rr.w_rb, obs_rr.acc, obs_rr.wdata} = {rr_s_addr, rr_s_w_rb, rr_s_acc, rr_s_wdata};
    obs_rr.r0 = rr_m0_resp;
    obs_rr.r1 = rr_m1_resp;
    obs_rr.f0 = rr_m0_fault;
    obs_rr.f1 = rr_m1_fault;
    if (rr_m0_resp) obs_rr.d0 = rr_m0_rdata;
    if (rr_m1_resp) obs_rr.d1 = rr_m1_rdata;
    obs_fx = '0;
    obs_fx.req = fx_s_req;
    if (fx_s_req) {obs_fx.addr, obs_fx.w_rb, obs_fx.acc, obs_fx.wdata} = {fx_s_addr, fx_s_w_rb, fx_s_acc, fx_s_wdata};
    obs_fx.r0 = fx_m0_resp;
    obs_fx.r1 = fx_m1_resp;
    obs_fx.f0 = fx_m0_fault;
    obs_fx.f1 = fx_m1_fault;
    if (fx_m0_resp) obs_fx.d0 = fx_m0_rdata;
    if (fx_m1_resp) obs_fx.d1 = fx_m1_rdata;
  end

  stim_t sq[$];
  obs_t  eq[$];
  int    n_chk = 0;
  int    n_fail = 0;

  function automatic stim_t m0(input logic q, input logic [2:0] a, input logic w,
                               input logic [1:0] c, input logic [31:0] d);
    stim_t s = '0;
    s.q0 = q; s.a0 = a; s.w0 = w; s.c0 = c; s.d0 = d;
    return s;
  endfunction

  function automatic stim_t m1(input logic q, input logic [2:0] a, input logic w,
                               input logic [1:0] c, input logic [31:0] d);
    stim_t s = '0;
    s.q1 = q; s.a1 = a; s.w1 = w; s.c1 = c; s.d1 = d;
    return s;
  endfunction

  function automatic stim_t both(input stim_t x, input stim_t y);
    return stim_t'(x | y);
  endfunction

  function automatic stim_t st_rst();
    stim_t s = '0;
    s.rst = 1'b1;
    return s;
  endfunction

  function automatic stim_t st_inj();
    stim_t s = '0;
    s.inj = 1'b1;
    return s;
  endfunction

  function automatic obs_t e_iss(input logic [2:0] a, input logic w, input logic [1:0] c,
                                 input logic [31:0] d);
    obs_t e = '0;
    e.req = 1'b1; e.addr = a; e.w_rb = w; e.acc = c; e.wdata = d;
    return e;
  endfunction

  function automatic obs_t e_r0(input logic [2:0] a);
    obs_t e = '0;
    e.r0 = 1'b1; e.d0 = RD_BASE | 32'(a);
    return e;
  endfunction

  function automatic obs_t e_r1(input logic [2:0] a);
    obs_t e = '0;
    e.r1 = 1'b1; e.d1 = RD_BASE | 32'(a);
    return e;
  endfunction

  task automatic cyc(input stim_t s, input obs_t e);
    sq.push_back(s);
    eq.push_back(e);
  endtask

  task automatic apply(input stim_t s);
    rstn = ~s.rst; inj = s.inj;
    m0_req = s.q0; m0_addr = s.a0; m0_w_rb = s.w0; m0_acc = s.c0; m0_wdata = s.d0;
    m1_req = s.q1; m1_addr = s.a1; m1_w_rb = s.w1; m1_acc = s.c1; m1_wdata = s.d1;
  endtask

  task automatic test_reset();
    obs_t e;
    int c = 0;
    cyc(both(st_rst(), m0(1'b1, 3'd1, 1'b0, BUS_ACC_1B, '0)), '0);
    cyc(both(st_rst(), m1(1'b1, 3'd3, 1'b0, BUS_ACC_1B, '0)), '0);
    cyc('0, '0);
    while (sq.size() != 0) begin
      apply(sq.pop_front());
      @(negedge clk);
      e = eq.pop_front();
      n_chk++;
      if (obs_rr !== e) begin
        n_fail++;
        $display("FAIL reset c%0d: got %h want %h", c, obs_rr, e);
      end
      c++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lone_write();
    obs_t e;
    int c = 0;
    cyc(m0(1'b1, 3'd0, 1'b1, BUS_ACC_1B, 32'h41), e_iss(3'd0, 1'b1, BUS_ACC_1B, 32'h41));
    cyc('0, e_r0(3'd0));
    cyc('0, '0);
    while (sq.size() != 0) begin
      apply(sq.pop_front());
      @(negedge clk);
      e = eq.pop_front();
      n_chk++;
      if (obs_rr !== e) begin
        n_fail++;
        $display("FAIL lone_write c%0d: got %h want %h", c, obs_rr, e);
      end
      c++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rr_tie();
    obs_t e;
    int c = 0;
    cyc(st_rst(), '0);
    cyc(both(m0(1'b1, 3'd3, 1'b0, BUS_ACC_1B, '0), m1(1'b1, 3'd2, 1'b0, BUS_ACC_1B, '0)),
        e_iss(3'd3, 1'b0, BUS_ACC_1B, '0));
    cyc('0, e_r0(3'd3));
    // m0 comes back while m1 is pending: m1 was not last, so it goes first
    cyc(m0(1'b1, 3'd1, 1'b0, BUS_ACC_1B, '0), e_iss(3'd2, 1'b0, BUS_ACC_1B, '0));
    cyc('0, e_r1(3'd2));
    cyc('0, e_iss(3'd1, 1'b0, BUS_ACC_1B, '0));
    cyc('0, e_r0(3'd1));
    cyc(both(m0(1'b1, 3'd0, 1'b0, BUS_ACC_1B, '0), m1(1'b1, 3'd1, 1'b0, BUS_ACC_1B, '0)),
        e_iss(3'd1, 1'b0, BUS_ACC_1B, '0));
    cyc('0, e_r1(3'd1));
    cyc('0, e_iss(3'd0, 1'b0, BUS_ACC_1B, '0));
    cyc('0, e_r0(3'd0));
    while (sq.size() != 0) begin
      apply(sq.pop_front());
      @(negedge clk);
      e = eq.pop_front();
      n_chk++;
      if (obs_rr !== e) begin
        n_fail++;
        $display("FAIL rr_tie c%0d: got %h want %h", c, obs_rr, e);
      end
      c++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_live_fault();
    obs_t e, f;
    int c = 0;
    f = e_iss(3'd2, 1'b1, BUS_ACC_1B, 32'h55);
    f.f1 = 1'b1;
    cyc(m1(1'b1, 3'd2, 1'b1, BUS_ACC_1B, 32'h55), f);
    cyc(m0(1'b1, 3'd3, 1'b0, BUS_ACC_1B, '0), e_iss(3'd3, 1'b0, BUS_ACC_1B, '0));
    cyc('0, e_r0(3'd3));
    cyc('0, '0);
    while (sq.size() != 0) begin
      apply(sq.pop_front());
      @(negedge clk);
      e = eq.pop_front();
      n_chk++;
      if (obs_rr !== e) begin
        n_fail++;
        $display("FAIL live_fault c%0d: got %h want %h", c, obs_rr, e);
      end
      c++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_deferred_fault();
    obs_t e, f;
    int c = 0;
    f = e_iss(3'd1, 1'b0, BUS_ACC_2B, '0);
    f.f1 = 1'b1;
    cyc(st_rst(), '0);
    cyc(both(m0(1'b1, 3'd0, 1'b0, BUS_ACC_1B, '0), m1(1'b1, 3'd1, 1'b0, BUS_ACC_2B, '0)),
        e_iss(3'd0, 1'b0, BUS_ACC_1B, '0));
    cyc('0, e_r0(3'd0));
    cyc('0, f);
    cyc('0, '0);
    cyc('0, '0);
    while (sq.size() != 0) begin
      apply(sq.pop_front());
      @(negedge clk);
      e = eq.pop_front();
      n_chk++;
      if (obs_rr !== e) begin
        n_fail++;
        $display("FAIL deferred_fault c%0d: got %h want %h", c, obs_rr, e);
      end
      c++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_capture_wait();
    obs_t e, r;
    int c = 0;
    r = e_r0(3'd1);
    cyc(m0(1'b1, 3'd1, 1'b1, BUS_ACC_1B, 32'h11), e_iss(3'd1, 1'b1, BUS_ACC_1B, 32'h11));
    cyc(m1(1'b1, 3'd4, 1'b1, BUS_ACC_1B, 32'h77), r);
    cyc(m1(1'b0, 3'd5, 1'b0, BUS_ACC_4B, 32'h99), e_iss(3'd4, 1'b1, BUS_ACC_1B, 32'h77));
    cyc('0, e_r1(3'd4));
    cyc('0, '0);
    while (sq.size() != 0) begin
      apply(sq.pop_front());
      @(negedge clk);
      e = eq.pop_front();
      n_chk++;
      if (obs_rr !== e) begin
        n_fail++;
        $display("FAIL capture_wait c%0d: got %h want %h", c, obs_rr, e);
      end
      c++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fixed_prio();
    obs_t e;
    int c = 0;
    cyc(st_rst(), '0);
    cyc(both(m0(1'b1, 3'd3, 1'b0, BUS_ACC_1B, '0), m1(1'b1, 3'd2, 1'b0, BUS_ACC_1B, '0)),
        e_iss(3'd3, 1'b0, BUS_ACC_1B, '0));
    cyc('0, e_r0(3'd3));
    cyc(m0(1'b1, 3'd1, 1'b0, BUS_ACC_1B, '0), e_iss(3'd1, 1'b0, BUS_ACC_1B, '0));
    cyc('0, e_r0(3'd1));
    cyc(m0(1'b1, 3'd0, 1'b0, BUS_ACC_1B, '0), e_iss(3'd0, 1'b0, BUS_ACC_1B, '0));
    cyc('0, e_r0(3'd0));
    cyc('0, e_iss(3'd2, 1'b0, BUS_ACC_1B, '0));
    cyc('0, e_r1(3'd2));
    while (sq.size() != 0) begin
      apply(sq.pop_front());
      @(negedge clk);
      e = eq.pop_front();
      n_chk++;
      if (obs_fx !== e) begin
        n_fail++;
        $display("FAIL fixed_prio c%0d: got %h want %h", c, obs_fx, e);
      end
      c++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    obs_t e;
    int c = 0;
    cyc(st_rst(), '0);
    cyc(both(m0(1'b1, 3'd3, 1'b0, BUS_ACC_1B, '0), m1(1'b1, 3'd2, 1'b0, BUS_ACC_1B, '0)),
        e_iss(3'd3, 1'b0, BUS_ACC_1B, '0));
    cyc(st_rst(), '0);
    cyc(st_inj(), '0);
    cyc(both(m0(1'b1, 3'd1, 1'b0, BUS_ACC_1B, '0), m1(1'b1, 3'd0, 1'b0, BUS_ACC_1B, '0)),
        e_iss(3'd1, 1'b0, BUS_ACC_1B, '0));
    cyc('0, e_r0(3'd1));
    cyc('0, e_iss(3'd0, 1'b0, BUS_ACC_1B, '0));
    cyc('0, e_r1(3'd0));
    while (sq.size() != 0) begin
      apply(sq.pop_front());
      @(negedge clk);
      e = eq.pop_front();
      n_chk++;
      if (obs_rr !== e) begin
        n_fail++;
        $display("FAIL reset_mid c%0d: got %h want %h", c, obs_rr, e);
      end
      c++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_lone_write();
    test_rr_tie();
    test_live_fault();
    test_deferred_fault();
    test_capture_wait();
    test_fixed_prio();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
